// File: rtl/hilo_divider.sv
// Execute-stage iterative signed divider owning the HI/LO registers.
// One restoring step per cycle; MFHI/MFLO read HI/LO combinationally and stall while a divide runs.
module hilo_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             has_div_e,
  input  logic             is_mf_hi_e,
  input  logic             is_mf_lo_e,
  input  logic             flush_e,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hilo_out,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    FIX_Z
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic             sign_q;
  logic             sign_r;
  logic [CNT_W-1:0] counter;

  logic             start;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_shift;
  logic             fits;
  logic [WIDTH-1:0] rem_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    start     = 1'b0;
    mag_a     = src_a;
    mag_b     = src_b;
    rem_shift = {rem, quo[WIDTH-1]};
    fits      = 1'b0;
    rem_next  = rem_shift[WIDTH-1:0];

    start = (state == IDLE) && has_div_e && !flush_e;
    if (src_a[WIDTH-1]) mag_a = -src_a;
    if (src_b[WIDTH-1]) mag_b = -src_b;

    // The shifted remainder can exceed WIDTH bits, so the compare keeps a guard bit.
    fits = rem_shift >= {1'b0, divisor};
    if (fits) rem_next = WIDTH'(rem_shift - {1'b0, divisor});
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  // NOTE: the datapath registers are few and are reset along with the control state, which keeps
  // simulation free of X and costs nothing meaningful here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      quo         <= '0;
      rem         <= '0;
      divisor     <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      counter     <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= (src_b == '0);
            if (src_b == '0) begin
              quo   <= src_a;
              state <= FIX_Z;
            end else begin
              quo     <= mag_a;
              divisor <= mag_b;
              sign_q  <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
              sign_r  <= src_a[WIDTH-1];
              rem     <= '0;
              counter <= CNT_W'(WIDTH);
              state   <= CALC;
            end
          end
        end
        CALC: begin
          rem     <= rem_next;
          quo     <= {quo[WIDTH-2:0], fits};
          counter <= counter - 1'b1;
          if (counter == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          lo    <= sign_q ? -quo : quo;
          hi    <= sign_r ? -rem : rem;
          state <= IDLE;
        end
        FIX_Z: begin
          hi    <= quo;
          lo    <= {WIDTH{1'b1}};
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign stall    = busy && (has_div_e || is_mf_hi_e || is_mf_lo_e);
  assign hilo_out = is_mf_hi_e ? hi : lo;

endmodule
